// File: rtl/intm_cdb_arb_pkg.sv
// Shared types and default parameters for the integer mul/div CDB arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   fu_cdb_reg_t          - result payload carried from a functional unit to the CDB
//   INTM_CDB_FIFO_DEPTH   - default entries per source FIFO
//   INTM_CDB_STARVE_LIMIT - default lost-arbitration limit for the multiply source
package intm_cdb_arb_pkg;

    localparam int INTM_CDB_FIFO_DEPTH   = 2;
    localparam int INTM_CDB_STARVE_LIMIT = 4;

    localparam int ROB_ID_W = 6;
    localparam int XLEN     = 32;

    typedef struct packed {
        logic [ROB_ID_W-1:0] rob_id;
        logic [XLEN-1:0]     result;
        logic                exc;
    } fu_cdb_reg_t;

endpackage

// File: rtl/intm_cdb_fifo.sv
// Small synchronous FIFO for one result source, parameterised on payload type and depth.
// Latency: 1 edge from push to head visible (no bypass).
// Backpressure: push_rdy depends on registered count only; a same-cycle pop never raises it.
//
// Ports:
//   clk, rst_n          - clock, async active-low reset (pointers and count cleared)
//   push_vld/push_rdy   - write handshake, push_dat written at tail when both high
//   push_dat            - payload in
//   pop_vld             - consume head this edge (ignored when empty)
//   head_vld/head_dat   - FIFO non-empty / payload at head
//   cnt                 - occupancy, width $clog2(DEPTH)+1
module intm_cdb_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_vld,
    output logic          push_rdy,
    input  T              push_dat,
    input  logic          pop_vld,
    output logic          head_vld,
    output T              head_dat,
    output logic [CW-1:0] cnt
);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign push_rdy = (cnt != CW'(DEPTH));
    assign head_vld = (cnt != '0);
    assign head_dat = mem[rd_ptr];
    assign push     = push_vld && push_rdy;
    assign pop      = pop_vld && head_vld;

    // Storage is not reset: entries are only visible through cnt, which is.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/intm_cdb_arb.sv
// Arbitrates multiply and divide results onto one CDB slot through a registered output stage.
// Latency: 2 edges minimum (FIFO write, then output register load); 1 result/cycle throughput.
// Backpressure: output holds while cdb_valid && !cdb_ready; source readys reflect FIFO fullness only.
//
// Ports:
//   clk, rst_n                        - clock, async active-low reset
//   mul_valid/mul_ready/mul_data      - multiplier result handshake and payload
//   div_valid/div_ready/div_data      - divider result handshake and payload
//   cdb_ready/cdb_valid/cdb_data      - CDB slot handshake and registered payload
//   mul_cnt, div_cnt                  - per-source FIFO occupancy
//
// Build option: define INTM_CDB_ARB_STARVE_EN to compile in the multiply starvation guard.
// Without it, divide results have strict priority and a divide stream can hold off
// multiply results indefinitely.
module intm_cdb_arb
    import intm_cdb_arb_pkg::*;
#(
    parameter int  FIFO_DEPTH   = INTM_CDB_FIFO_DEPTH,
    parameter int  STARVE_LIMIT = INTM_CDB_STARVE_LIMIT,
    localparam int CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mul_valid,
    output logic          mul_ready,
    input  fu_cdb_reg_t   mul_data,
    input  logic          div_valid,
    output logic          div_ready,
    input  fu_cdb_reg_t   div_data,
    input  logic          cdb_ready,
    output logic          cdb_valid,
    output fu_cdb_reg_t   cdb_data,
    output logic [CW-1:0] mul_cnt,
    output logic [CW-1:0] div_cnt
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    logic        mul_head_vld;
    logic        div_head_vld;
    fu_cdb_reg_t mul_head_dat;
    fu_cdb_reg_t div_head_dat;
    logic        load;
    logic        grant_mul;
    logic        grant_div;
    logic        mul_force;

    intm_cdb_fifo #(
        .T     (fu_cdb_reg_t),
        .DEPTH (FIFO_DEPTH)
    ) u_mul_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (mul_valid),
        .push_rdy (mul_ready),
        .push_dat (mul_data),
        .pop_vld  (grant_mul),
        .head_vld (mul_head_vld),
        .head_dat (mul_head_dat),
        .cnt      (mul_cnt)
    );

    intm_cdb_fifo #(
        .T     (fu_cdb_reg_t),
        .DEPTH (FIFO_DEPTH)
    ) u_div_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (div_valid),
        .push_rdy (div_ready),
        .push_dat (div_data),
        .pop_vld  (grant_div),
        .head_vld (div_head_vld),
        .head_dat (div_head_dat),
        .cnt      (div_cnt)
    );

    // The output register can take a new result when it is empty or being drained.
    assign load = !cdb_valid || cdb_ready;

`ifdef INTM_CDB_ARB_STARVE_EN
    // Counts loads where multiply had a result waiting but divide won.
    // Once it reaches the limit the next load with multiply pending goes to multiply,
    // which clears the counter, so saturation is only a safety bound.
    logic [3:0] starve_cnt;

    assign mul_force = (starve_cnt == 4'(STARVE_LIMIT)) && mul_head_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!mul_head_vld || grant_mul) begin
            starve_cnt <= '0;
        end else if (grant_div && (starve_cnt != 4'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign mul_force = 1'b0;
`endif

    always_comb begin
        grant_mul = 1'b0;
        grant_div = 1'b0;
        if (load) begin
            if (mul_force) begin
                grant_mul = 1'b1;
            end else if (div_head_vld) begin
                grant_div = 1'b1;
            end else if (mul_head_vld) begin
                grant_mul = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
        end else if (load) begin
            if (grant_mul) begin
                cdb_valid <= 1'b1;
                cdb_data  <= mul_head_dat;
            end else if (grant_div) begin
                cdb_valid <= 1'b1;
                cdb_data  <= div_head_dat;
            end else begin
                // Nothing to send; payload keeps its last value but is not valid.
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule
